// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed 7-segment scan controller.
// Latches a 16-bit value once per frame, presents one nibble per digit slot
// to the downstream registered hex decoder, and drives active-low digit
// selects that line up with the decoder output one cycle after the nibble.
// Optional feature macro: SEG_SCAN_LZB_EN (leading-zero blanking).
module seg_scan #(
    parameter int unsigned SCAN_DIV = 25000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        blank,
    output logic [3:0]  hex,
    output logic [3:0]  dig_sel,
    output logic        frame
);

    localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  hex_q, hex_d;
    logic [3:0]  dig_sel_q, dig_sel_d;
    logic        frame_q, frame_d;

    logic        tick_s;
    logic [1:0]  idx_next_s;
    logic        suppress_s;

    // Pick nibble i out of a 16-bit word.
    function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] i);
        logic [3:0] r;
        case (i)
            2'd0:    r = v[3:0];
            2'd1:    r = v[7:4];
            2'd2:    r = v[11:8];
            2'd3:    r = v[15:12];
            default: r = 4'h0;
        endcase
        return r;
    endfunction

`ifdef SEG_SCAN_LZB_EN
    // A digit is a leading zero when it and every more significant nibble are 0;
    // digit 0 always stays lit so a zero value still shows "0".
    function automatic logic digit_suppressed(input logic [15:0] v, input logic [1:0] i);
        logic r;
        case (i)
            2'd0:    r = 1'b0;
            2'd1:    r = (v[15:4]  == 12'h000);
            2'd2:    r = (v[15:8]  == 8'h00);
            2'd3:    r = (v[15:12] == 4'h0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Suppression looks at the shadow copy so it cannot change mid-frame.
    always_comb begin
        suppress_s = digit_suppressed(shadow_q, idx_q);
    end
`else
    // Without leading-zero blanking every digit is always eligible.
    always_comb begin
        suppress_s = 1'b0;
    end
`endif

    assign tick_s     = (cnt_q == CNT_MAX);
    assign idx_next_s = idx_q + 2'd1;

    // Next-state for divider, digit index, shadow and the registered outputs.
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        hex_d     = hex_q;
        dig_sel_d = dig_sel_q;
        frame_d   = 1'b0;
        if (tick_s) begin
            cnt_d     = 16'd0;
            idx_d     = idx_next_s;
            frame_d   = (idx_next_s == 2'd0);
            // Guard cycle: all digits off while the decoder catches up.
            dig_sel_d = 4'hF;
            if (idx_next_s == 2'd0) begin
                // Frame boundary: capture the value and show its digit 0 at once.
                shadow_d = value;
                hex_d    = value[3:0];
            end else begin
                hex_d = nibble_sel(shadow_q, idx_next_s);
            end
        end else begin
            cnt_d = cnt_q + 16'd1;
            if (blank || suppress_s) begin
                dig_sel_d = 4'hF;
            end else begin
                dig_sel_d = ~(4'b0001 << idx_q);
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // idx=3 and cnt at terminal count make the first released cycle
            // a tick that loads value and starts digit 0.
            cnt_q     <= CNT_MAX;
            idx_q     <= 2'd3;
            shadow_q  <= 16'h0000;
            hex_q     <= 4'h0;
            dig_sel_q <= 4'hF;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            hex_q     <= hex_d;
            dig_sel_q <= dig_sel_d;
            frame_q   <= frame_d;
        end
    end

    assign hex     = hex_q;
    assign dig_sel = dig_sel_q;
    assign frame   = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Testbench for seg_scan: random and directed stimulus against a cycle-count
// reference model (slot/phase derived from elapsed cycles since reset release).
module tb_seg_scan;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        blank;
    logic [3:0]  hex;
    logic [3:0]  dig_sel;
    logic        frame;

    int n_cmp;
    int n_err;

    // Reference model state
    int          t;
    int          m_dig;
    int          m_p;
    logic [15:0] shadow_m;
    logic [3:0]  e_hex;
    logic [3:0]  e_sel;
    logic        e_frame;

    seg_scan #(.SCAN_DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .value   (value),
        .blank   (blank),
        .hex     (hex),
        .dig_sel (dig_sel),
        .frame   (frame)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, act, exp, t);
        end
    endtask

    function automatic logic lzb(input logic [15:0] v, input int d);
`ifdef SEG_SCAN_LZB_EN
        return (d > 0) && ((v >> (4 * d)) == 16'h0000);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: update the model from the inputs seen at the edge, then compare.
    task automatic step();
        int slot;
        @(posedge clk);
        if (!rst_n) begin
            t        = 0;
            m_dig    = -1;
            m_p      = -1;
            shadow_m = 16'h0000;
            e_hex    = 4'h0;
            e_sel    = 4'hF;
            e_frame  = 1'b0;
        end else begin
            t++;
            slot  = (t - 1) / DIV;
            m_p   = (t - 1) % DIV;
            m_dig = slot % 4;
            if (m_p == 0 && m_dig == 0) shadow_m = value;
            e_frame = (m_p == 0 && m_dig == 0);
            e_hex   = 4'((shadow_m >> (4 * m_dig)) & 16'h000F);
            if (m_p == 0 || blank || lzb(shadow_m, m_dig))
                e_sel = 4'hF;
            else
                e_sel = ~(4'b0001 << m_dig);
        end
        #1;
        check_eq("hex",     {12'h000, hex},     {12'h000, e_hex});
        check_eq("dig_sel", {12'h000, dig_sel}, {12'h000, e_sel});
        check_eq("frame",   {15'h0000, frame},  {15'h0000, e_frame});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model is in the given digit slot at the given phase.
    task automatic wait_slot(input int d, input int p);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 8 * DIV + 8 && !found; k++) begin
            if (m_dig == d && m_p == p) found = 1'b1;
            else step();
        end
        if (!found) check_eq("wait_timeout", 16'h0000, 16'h0001);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        t     = 0;
        m_dig = -1;
        m_p   = -1;
        shadow_m = 16'h0000;
        rst_n = 1'b0;
        value = 16'h1234;
        blank = 1'b0;

        // Reset hold, release with 1234 and run two frames
        run(3);
        rst_n = 1'b1;
        run(2 * 4 * DIV);

        // Tear-free update during digit 1
        wait_slot(1, 2);
        value = 16'hABCD;
        run(2 * 4 * DIV);

        // Blank for 5 cycles mid-slot
        wait_slot(2, 1);
        blank = 1'b1;
        run(5);
        blank = 1'b0;
        run(4 * DIV);

        // Leading zero patterns
        value = 16'h0050;
        run(3 * 4 * DIV);
        value = 16'h0000;
        run(3 * 4 * DIV);
        value = 16'h0700;
        run(2 * 4 * DIV);

        // Value change in the tick ending digit 3
        wait_slot(3, DIV - 1);
        value = 16'h5A5A;
        run(4 * DIV);

        // Reset mid-frame during digit 2
        wait_slot(2, 2);
        value = 16'h9876;
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(2 * 4 * DIV);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0:       value = 16'h0000;
                    1:       value = 16'($urandom_range(0, 255));
                    default: value = 16'($urandom);
                endcase
            end
            if ($urandom_range(0, 29) == 0) blank = ~blank;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                run($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Four-digit multiplexed scan controller for the 7-segment display path. It latches a 16-bit value once per frame and presents one hex nibble at a time to the downstream hex-to-segment decoder. It drives the active-low digit-select lines so that each select is aligned with the decoder's registered segment output, which arrives one cycle after the nibble. It sits between the counter/datapath logic and the hex decoder on the Alchitry Cu + Io display.

## Interface
- `SCAN_DIV`, default 25000: clock cycles per digit slot. Legal range 2..65535. At 100 MHz this gives a 4 kHz digit rate and a 1 kHz frame rate.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `value`  in  16  value to display; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3.
- `blank`  in  1  1 = all digits off; the scan continues underneath.
- `hex`  out  4  current nibble, to the decoder's hex input.
- `dig_sel`  out  4  active-low digit enables; bit i drives digit i.
- `frame`  out  1  one-cycle pulse, high in the cycle in which digit 0's nibble first appears on `hex`.

## Operation
- Divider `cnt`, 16 bit, counts 0..SCAN_DIV-1 and wraps.
- `tick` = (`cnt` == SCAN_DIV-1).
- Digit index `idx`, 2 bit, advances on `tick`: 0→1→2→3→0.
- Shadow register `shadow`, 16 bit: `shadow <= value` only on a `tick` where `idx` goes 3→0. `value` changes inside a frame never tear the display.
- On the clock edge ending a `tick` cycle (next index n = idx+1 mod 4):
  - `hex <=` nibble n of `shadow`. When n = 0, it takes nibble 0 of `value` directly, the same value being loaded into `shadow`.
  - `frame <= (n == 0)`. It is 0 on all other edges.
  - `dig_sel <= 4'hF`: a one-cycle guard to prevent ghosting.
- On every other edge, `dig_sel` is set as follows:
  - `4'hF` if `blank` is 1 or the current digit is suppressed (see Configuration).
  - Otherwise `~(4'b0001 << idx)`.
  - The enable pattern is re-evaluated every non-guard cycle, so `blank` takes effect within one cycle at any point in a slot.
- Reset values (`rst_n` = 0 at an edge):
  - `cnt` = SCAN_DIV-1, `idx` = 3, `shadow` = 0.
  - `hex` = 0, `dig_sel` = 4'hF, `frame` = 0.
  - The first cycle after release is therefore a `tick` that loads `value` and starts digit 0.
- Reset asserted mid-slot or mid-frame aborts the scan immediately and produces the reset values at the next edge. There is no partial-frame completion.

## Timing
- Tick at cycle k:
  - k+1: `hex`/`idx` updated, `dig_sel` = F (guard), `frame` valid.
  - k+2: decoder output valid and `dig_sel` active.
- Each digit is lit SCAN_DIV-1 cycles per slot. The frame period is 4·SCAN_DIV cycles.
- Latency from a `value` change to display depends on when it occurs:
  - Normally: up to 4·SCAN_DIV+2 cycles, at the next frame boundary.
  - If `value` changes in the tick cycle that ends digit 3: it is captured at that tick, and digit 0 lights 2 cycles later.
- `blank`: 1-cycle latency to `dig_sel`. It has no effect on `hex`, `frame` or `shadow`.
- SCAN_DIV = 2: one guard cycle and one lit cycle per slot; operation is otherwise identical.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking.
  - Digit i (i ≥ 1) is suppressed when `shadow[4i+3:4i]` and all more significant nibbles are 0.
  - Digit 0 is never suppressed.
  - The check uses `shadow`, so it is stable within a frame.
- Macro undefined: all four digits are always shown (when `blank` = 0), including leading zeros. The zero-check logic is absent.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles → `dig_sel` = F, `hex` = 0, `frame` = 0. Release with `value` = 16'h1234 → next cycle `hex` = 4 and `frame` = 1. One cycle later `dig_sel` = 4'b1110.
- Scan, SCAN_DIV = 4, `value` = 16'h1234:
  - `hex` sequence 4, 3, 2, 1, each held 4 cycles.
  - `dig_sel` per slot is F, then 1110 / 1101 / 1011 / 0111 for 3 cycles.
  - `frame` pulses every 16 cycles.
- Tear-free update: change `value` to 16'hABCD during digit 1's slot → remaining digits still show 2, 1. The next frame shows D, C, B, A.
- Blank: assert `blank` for 5 cycles in mid-slot → `dig_sel` = F from the next cycle. `hex`/`frame` cadence is unchanged. The select pattern returns 1 cycle after deassert.
- LZB: with `SEG_SCAN_LZB_EN` defined:
  - `value` = 16'h0050 → digits 3 and 2 stay F; digits 1 and 0 light.
  - `value` = 16'h0000 → only digit 0 lights.
  - Without the macro, all 4 digits light in both cases.
- Reset mid-frame during digit 2 → outputs take reset values next edge. Scan restarts at digit 0 with the current `value`.
